bus_transfer_decoder: RTL and testbench

- Sequenced inverse of the bus source encoder: accepts a 5-bit source code and a 5-bit destination code via valid/ready handshake.
- Drives the one-hot 32-bit bus-drive enables for the source and the one-hot 32-bit register-load strobes for the destination, in a fixed drive -> load -> done sequence.
- Sits in the control path between the control unit and the datapath bus/register file.
- Code map matches the bus encoder exactly:
  - code 0 = no source/destination;
  - code k (1..23) = bit k-1;
  - codes 24..31 are invalid (31 = encoder "nothing selected").

---
 rtl/bus_transfer_decoder.sv | 140 ++++++++++++++
 tb/tb_bus_transfer_decoder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/bus_transfer_decoder.sv
// bus_transfer_decoder: accepts a source/destination code pair over a
// valid/ready handshake and sequences the one-hot bus-drive enables and
// register-load strobes through drive -> load -> done. The code map matches the
// bus encoder: 0 = nothing, k in 1..23 = bit k-1, 24..31 are illegal.
module bus_transfer_decoder #(
  parameter int unsigned DRIVE_CYCLES = 1,  // bus settle cycles before the load, 1..15
  parameter int unsigned COUNT_W      = 16  // width of the successful-transfer counter
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [4:0]         req_src,
  input  logic [4:0]         req_dst,
  output logic [31:0]        bus_drive,
  output logic [31:0]        bus_load,
  output logic               xfer_done,
  output logic               xfer_err,
  output logic [COUNT_W-1:0] xfer_count
);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    LOAD,
    DONE,
    ERR
  } state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(DRIVE_CYCLES);

  state_t      state, state_next;
  logic [4:0]  src_q, dst_q, src_next, dst_next;
  logic [3:0]  settle, settle_next;
  logic [31:0] drive_next, load_next;
  logic        done_next, err_next;
  logic        count_inc;
  logic        accept;
  logic        req_bad;

  // Encoder code to one-hot enable; illegal codes map to zero so that no
  // out-of-range enable can ever be produced.
  function automatic logic [31:0] onehot(input logic [4:0] code);
    logic [31:0] vec;
    vec = '0;
    if (code != 5'd0 && code < 5'd24) vec = 32'h1 << (code - 5'd1);
    return vec;
  endfunction

  assign req_ready = (state == IDLE) && !clear;
  assign accept    = req_valid && req_ready;

  // A request is rejected for an illegal code, a missing destination, or a
  // register copied onto itself.
  assign req_bad = (req_src >= 5'd24) || (req_dst >= 5'd24) || (req_dst == 5'd0) ||
                   ((req_src == req_dst) && (req_src != 5'd0));

  // Next-state and next-output decode; outputs are registered from these values
  // so each output lines up with the state it belongs to.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_next  = state;
    src_next    = src_q;
    dst_next    = dst_q;
    settle_next = settle;
    drive_next  = '0;
    load_next   = '0;
    done_next   = 1'b0;
    err_next    = 1'b0;
    count_inc   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          src_next = req_src;
          dst_next = req_dst;
          if (req_bad) begin
            state_next = ERR;
            done_next  = 1'b1;
            err_next   = 1'b1;
          end else begin
            state_next  = DRIVE;
            settle_next = SETTLE_INIT;
            drive_next  = onehot(req_src);
          end
        end
      end
      DRIVE: begin
        drive_next = onehot(src_q);
        if (settle == 4'd1) begin
          state_next = LOAD;
          load_next  = onehot(dst_q);
        end else begin
          settle_next = settle - 4'd1;
        end
      end
      LOAD: begin
        state_next = DONE;
        done_next  = 1'b1;
        count_inc  = 1'b1;
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control state, registered outputs and the transfer counter; clear aborts
  // any transfer in flight without a completion pulse.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (clear) begin
      state      <= IDLE;
      settle     <= '0;
      bus_drive  <= '0;
      bus_load   <= '0;
      xfer_done  <= 1'b0;
      xfer_err   <= 1'b0;
      xfer_count <= '0;
    end else begin
      state     <= state_next;
      settle    <= settle_next;
      bus_drive <= drive_next;
      bus_load  <= load_next;
      xfer_done <= done_next;
      xfer_err  <= err_next;
      if (count_inc) xfer_count <= xfer_count + COUNT_W'(1);
    end
  end

  // Captured request codes.
  always_ff @(posedge clock) begin
    // NOTE: these hold data only and are always written on acceptance before
    // being read, so they carry no reset.
    src_q <= src_next;
    dst_q <= dst_next;
  end

endmodule

// File: tb/tb_bus_transfer_decoder.sv
// Directed testbench for bus_transfer_decoder: one instance with a single
// settle cycle and a 16-bit counter, one with three settle cycles and a 4-bit
// counter. Outputs are sampled on the falling clock edge.
module tb_bus_transfer_decoder;

  logic        clock;
  int          total = 0;
  int          bad   = 0;
  logic        mon_en = 1'b0;

  logic        a_clear, a_valid;
  logic [4:0]  a_src, a_dst;
  logic        a_ready, a_done, a_err;
  logic [31:0] a_drive, a_load;
  logic [15:0] a_count;

  logic        b_clear, b_valid;
  logic [4:0]  b_src, b_dst;
  logic        b_ready, b_done, b_err;
  logic [31:0] b_drive, b_load;
  logic [3:0]  b_count;

  logic [4:0]  err_src [4] = '{5'd24, 5'd3, 5'd7, 5'd1};
  logic [4:0]  err_dst [4] = '{5'd2, 5'd0, 5'd7, 5'd31};

  bus_transfer_decoder #(.DRIVE_CYCLES(1), .COUNT_W(16)) u_dut_a (
    .clock(clock), .clear(a_clear), .req_valid(a_valid), .req_ready(a_ready),
    .req_src(a_src), .req_dst(a_dst), .bus_drive(a_drive), .bus_load(a_load),
    .xfer_done(a_done), .xfer_err(a_err), .xfer_count(a_count)
  );

  bus_transfer_decoder #(.DRIVE_CYCLES(3), .COUNT_W(4)) u_dut_b (
    .clock(clock), .clear(b_clear), .req_valid(b_valid), .req_ready(b_ready),
    .req_src(b_src), .req_dst(b_dst), .bus_drive(b_drive), .bus_load(b_load),
    .xfer_done(b_done), .xfer_err(b_err), .xfer_count(b_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Enables are at most one-hot and never touch bits 23..31.
  always @(negedge clock) begin
    if (mon_en) begin
      check("a_onehot", 32'({$onehot0(a_drive), $onehot0(a_load)}), 32'h3);
      check("b_onehot", 32'({$onehot0(b_drive), $onehot0(b_load)}), 32'h3);
      check("range", 32'({a_drive[31:23], a_load[31:23], b_drive[31:23], b_load[31:23]}), 32'h0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones, last, cyc;
    logic pending;

    a_clear = 1'b1; a_valid = 1'b0; a_src = '0; a_dst = '0;
    b_clear = 1'b1; b_valid = 1'b0; b_src = '0; b_dst = '0;
    @(negedge clock);
    @(negedge clock);
    check("rst_drive", a_drive, 32'h0);
    check("rst_load", a_load, 32'h0);
    check("rst_done", {a_done, a_err}, 32'h0);
    check("rst_count", a_count, 32'h0);
    check("rst_ready", a_ready, 32'h0);
    a_clear = 1'b0; b_clear = 1'b0;
    @(negedge clock);
    check("idle_ready", a_ready, 32'h1);
    mon_en = 1'b1;

    // Nominal transfer src=5 dst=12 with a changed, re-pulsed request in DRIVE.
    a_valid = 1'b1; a_src = 5'd5; a_dst = 5'd12;
    @(negedge clock);                       // T+1
    check("nom_t1_drive", a_drive, 32'h10);
    check("nom_t1_load", a_load, 32'h0);
    check("nom_t1_ready", a_ready, 32'h0);
    a_src = 5'd9; a_dst = 5'd3;
    @(negedge clock);                       // T+2
    check("nom_t2_drive", a_drive, 32'h10);
    check("nom_t2_load", a_load, 32'h800);
    check("nom_t2_done", a_done, 32'h0);
    a_valid = 1'b0;
    @(negedge clock);                       // T+3
    check("nom_t3_drive", a_drive, 32'h0);
    check("nom_t3_load", a_load, 32'h0);
    check("nom_t3_done", {a_done, a_err}, 32'h2);
    @(negedge clock);                       // T+4
    check("nom_t4_ready", a_ready, 32'h1);
    check("nom_t4_count", a_count, 32'h1);
    check("nom_t4_idle", {a_done, a_drive}, 33'h0);

    // Rejected requests complete with an error pulse one cycle after acceptance.
    for (int i = 0; i < 4; i++) begin
      a_valid = 1'b1; a_src = err_src[i]; a_dst = err_dst[i];
      @(negedge clock);                     // T+1
      check($sformatf("err%0d_flags", i), {a_done, a_err}, 32'h3);
      check($sformatf("err%0d_bus", i), a_drive | a_load, 32'h0);
      a_valid = 1'b0;
      @(negedge clock);                     // T+2
      check($sformatf("err%0d_ready", i), a_ready, 32'h1);
      check($sformatf("err%0d_count", i), a_count, 32'h1);
      check($sformatf("err%0d_quiet", i), a_done, 32'h0);
    end

    // Clear asserted during LOAD aborts the transfer.
    a_valid = 1'b1; a_src = 5'd2; a_dst = 5'd4;
    @(negedge clock);                       // T+1
    check("abort_drive", a_drive, 32'h2);
    a_valid = 1'b0;
    @(negedge clock);                       // T+2 (LOAD)
    check("abort_load", a_load, 32'h8);
    a_clear = 1'b1;
    @(negedge clock);
    check("abort_bus", a_drive | a_load, 32'h0);
    check("abort_done", {a_done, a_err}, 32'h0);
    check("abort_count", a_count, 32'h0);
    check("abort_ready", a_ready, 32'h0);
    a_clear = 1'b0;
    @(negedge clock);
    check("abort_ready_back", a_ready, 32'h1);
    check("abort_no_done", a_done, 32'h0);

    // Zero source with three settle cycles.
    b_valid = 1'b1; b_src = 5'd0; b_dst = 5'd23;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);                     // T+k
      b_valid = 1'b0;
      check($sformatf("zs_t%0d_drive", k), b_drive, 32'h0);
      check($sformatf("zs_t%0d_load", k), b_load, (k == 4) ? 32'h0040_0000 : 32'h0);
      check($sformatf("zs_t%0d_done", k), {b_done, b_err}, (k == 5) ? 32'h2 : 32'h0);
    end
    @(negedge clock);                       // T+6
    check("zs_ready", b_ready, 32'h1);
    check("zs_count", b_count, 32'h1);

    // Seventeen back-to-back transfers on a 4-bit counter.
    b_clear = 1'b1;
    @(negedge clock);
    b_clear = 1'b0; b_valid = 1'b1; b_src = 5'd1; b_dst = 5'd2;
    dones = 0; last = 0; cyc = 0; pending = 1'b0;
    while ((dones < 17 || pending) && cyc < 300) begin
      @(negedge clock);
      cyc++;
      if (pending) begin
        if (dones == 16) check("wrap16_count", b_count, 32'h0);
        else             check("wrap17_count", b_count, 32'h1);
        pending = 1'b0;
      end
      if (b_done) begin
        dones++;
        if (dones > 1) check("b2b_spacing", cyc - last, 32'd6);
        last = cyc;
        if (dones >= 16) pending = 1'b1;
        if (dones == 17) b_valid = 1'b0;
      end
    end
    check("b2b_dones", dones, 32'd17);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
